// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and entry type for the write-back queue
package wb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/wb_match.sv
// rtl/wb_match.sv - youngest-entry bypass search for one register read address
module wb_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  entry_t [DEPTH-1:0]         ent_i,
  input  logic   [DEPTH-1:0]         vld_i,
  input  logic   [$clog2(DEPTH)-1:0] head_i,
  input  logic   [REG_W-1:0]         addr_i,
  output logic                       hit_o,
  output logic   [DATA_W-1:0]        data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (vld_i[idx] && (ent_i[idx].rd == addr_i) && (addr_i != '0)) begin
        hit_o  = 1'b1;
        data_o = ent_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - register-file write-back FIFO with read-port bypass
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Clr,
  input  logic                       In_valid,
  output logic                       In_ready,
  input  logic [REG_W-1:0]           In_reg,
  input  logic [DATA_W-1:0]          In_data,
  input  logic                       Hold,
  output logic                       We,
  output logic [REG_W-1:0]           Wr,
  output logic [DATA_W-1:0]          D,
  input  logic [REG_W-1:0]           Ra,
  input  logic [REG_W-1:0]           Rb,
  output logic                       Hit_a,
  output logic                       Hit_b,
  output logic [DATA_W-1:0]          Fa,
  output logic [DATA_W-1:0]          Fb,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Full,
  output logic                       Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t [DEPTH-1:0] ent_q;
  logic   [DEPTH-1:0] vld_q, vld_d;
  logic   [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic   [CW-1:0]    count_q, count_d;
  logic               push;

  assign Count    = count_q;
  assign Full     = (count_q == CW'(DEPTH));
  assign Empty    = (count_q == '0);
  assign We       = !Empty && !Hold;
  assign Wr       = ent_q[head_q].rd;
  assign D        = ent_q[head_q].data;
  assign In_ready = !Full || We;
  // r0 offers complete the handshake but are never stored.
  assign push     = In_valid && In_ready && (In_reg != '0);

  // Pop clears before push sets: when full, head and tail share a slot.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    vld_d   = vld_q;
    count_d = count_q + CW'(push) - CW'(We);
    if (We) begin
      head_d         = head_q + 1'b1;
      vld_d[head_q]  = 1'b0;
    end
    if (push) begin
      tail_d         = tail_q + 1'b1;
      vld_d[tail_q]  = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push && !Clr) begin
      ent_q[tail_q] <= '{rd: In_reg, data: In_data};
    end
  end

  wb_match #(.DEPTH(DEPTH)) u_match_a (
    .ent_i  (ent_q),
    .vld_i  (vld_q),
    .head_i (head_q),
    .addr_i (Ra),
    .hit_o  (Hit_a),
    .data_o (Fa)
  );

  wb_match #(.DEPTH(DEPTH)) u_match_b (
    .ent_i  (ent_q),
    .vld_i  (vld_q),
    .head_i (head_q),
    .addr_i (Rb),
    .hit_o  (Hit_b),
    .data_o (Fb)
  );

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - scoreboard bench for wb_queue
module tb_wb_queue;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic              Clk = 1'b0;
  logic              Clr = 1'b1;
  logic              In_valid = 1'b0;
  logic              In_ready;
  logic [REG_W-1:0]  In_reg = '0;
  logic [DATA_W-1:0] In_data = '0;
  logic              Hold = 1'b0;
  logic              We;
  logic [REG_W-1:0]  Wr;
  logic [DATA_W-1:0] D;
  logic [REG_W-1:0]  Ra = '0;
  logic [REG_W-1:0]  Rb = '0;
  logic              Hit_a, Hit_b;
  logic [DATA_W-1:0] Fa, Fb;
  logic [CW-1:0]     Count;
  logic              Full, Empty;

  int n_cmp = 0;
  int n_bad = 0;
  entry_t sb[$];

  wb_queue #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Clr(Clr), .In_valid(In_valid), .In_ready(In_ready),
    .In_reg(In_reg), .In_data(In_data), .Hold(Hold), .We(We), .Wr(Wr), .D(D),
    .Ra(Ra), .Rb(Rb), .Hit_a(Hit_a), .Hit_b(Hit_b), .Fa(Fa), .Fb(Fb),
    .Count(Count), .Full(Full), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] bypass(input logic [REG_W-1:0] a);
    logic [32:0] r;
    r = '0;
    if (a != '0)
      foreach (sb[i]) if (sb[i].rd == a) r = {1'b1, sb[i].data};
    return r;
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Cycle model: checks every output mid-cycle, then applies this edge's pop/push.
  always @(negedge Clk) begin
    int n;
    logic exp_we, exp_rdy;
    logic [32:0] ba, bb;
    entry_t e;
    if (Clr) begin
      sb.delete();
    end else begin
      n       = sb.size();
      exp_we  = (n != 0) && !Hold;
      exp_rdy = (n != DEPTH) || exp_we;
      ba      = bypass(Ra);
      bb      = bypass(Rb);
      chk("count", Count, n);
      chk("empty", Empty, n == 0);
      chk("full", Full, n == DEPTH);
      chk("we", We, exp_we);
      chk("in_ready", In_ready, exp_rdy);
      chk("hit_a", Hit_a, ba[32]);
      chk("fa", Fa, ba[31:0]);
      chk("hit_b", Hit_b, bb[32]);
      chk("fb", Fb, bb[31:0]);
      if (exp_we) begin
        e = sb.pop_front();
        chk("wr", Wr, e.rd);
        chk("d", D, e.data);
      end
      if (In_valid && exp_rdy && In_reg != '0)
        sb.push_back('{rd: In_reg, data: In_data});
    end
  end

  task automatic offer(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
    In_valid = 1'b1;
    In_reg   = r;
    In_data  = d;
    tick();
    In_valid = 1'b0;
  endtask

  task automatic drain;
    Hold = 1'b0;
    In_valid = 1'b0;
    for (int i = 0; i < 20 && !Empty; i++) tick();
    chk("drain_done", Empty, 1'b1);
  endtask

  initial begin
    tick();
    tick();
    Clr = 1'b0;
    Ra = 5'd3;
    Rb = 5'd5;
    chk("rst_we", We, 1'b0);
    chk("rst_empty", Empty, 1'b1);
    chk("rst_full", Full, 1'b0);
    chk("rst_ready", In_ready, 1'b1);
    chk("rst_hit_a", Hit_a, 1'b0);
    chk("rst_hit_b", Hit_b, 1'b0);
    chk("rst_fa", Fa, 32'h0);
    chk("rst_fb", Fb, 32'h0);

    // basic push then drain
    offer(5'd3, 32'hA5A5_0001);
    chk("basic_we", We, 1'b1);
    chk("basic_wr", Wr, 5'd3);
    chk("basic_d", D, 32'hA5A5_0001);
    chk("basic_count", Count, 1);
    tick();
    chk("basic_empty", Empty, 1'b1);

    // r0 is accepted and discarded
    In_valid = 1'b1; In_reg = 5'd0; In_data = 32'hDEAD;
    #1;
    chk("r0_ready", In_ready, 1'b1);
    tick();
    In_valid = 1'b0;
    chk("r0_count", Count, 0);
    chk("r0_we", We, 1'b0);
    tick();
    chk("r0_we2", We, 1'b0);

    // fill under Hold, then stream one per cycle while full
    Hold = 1'b1;
    for (int i = 1; i <= DEPTH; i++) offer(5'(i), 32'h100 + 32'(i));
    In_valid = 1'b1; In_reg = 5'd9; In_data = 32'h999;
    #1;
    chk("fill_full", Full, 1'b1);
    chk("fill_ready", In_ready, 1'b0);
    Hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      In_reg = 5'(10 + i);
      In_data = 32'h200 + 32'(i);
      #1;
      chk("stream_ready", In_ready, 1'b1);
      tick();
      chk("stream_count", Count, DEPTH);
    end
    drain();

    // bypass picks youngest entry per register
    Hold = 1'b1;
    offer(5'd5, 32'h11);
    offer(5'd5, 32'h22);
    offer(5'd7, 32'h33);
    Ra = 5'd5; Rb = 5'd7;
    #1;
    chk("byp_hit_a", Hit_a, 1'b1);
    chk("byp_fa", Fa, 32'h22);
    chk("byp_hit_b", Hit_b, 1'b1);
    chk("byp_fb", Fb, 32'h33);
    Ra = 5'd0;
    #1;
    chk("byp_r0_hit", Hit_a, 1'b0);
    chk("byp_r0_fa", Fa, 32'h0);
    drain();

    // reset with entries pending and a concurrent push
    Hold = 1'b1;
    offer(5'd4, 32'h44);
    offer(5'd6, 32'h66);
    offer(5'd8, 32'h88);
    In_valid = 1'b1; In_reg = 5'd9; In_data = 32'h99;
    Clr = 1'b1;
    tick();
    Clr = 1'b0; In_valid = 1'b0; Hold = 1'b0;
    Ra = 5'd4; Rb = 5'd9;
    chk("clr_count", Count, 0);
    chk("clr_we", We, 1'b0);
    chk("clr_hit_a", Hit_a, 1'b0);
    chk("clr_hit_b", Hit_b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_no_write", We, 1'b0);
    end

    // random traffic with frequent register collisions
    for (int i = 0; i < 300; i++) begin
      In_valid = 1'($urandom_range(0, 1));
      In_reg   = 5'($urandom_range(0, 7));
      In_data  = $urandom;
      Hold     = ($urandom_range(0, 3) == 0);
      Ra       = 5'($urandom_range(0, 7));
      Rb       = 5'($urandom_range(0, 7));
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
